// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the pipelined MIPS core.
// It owns HI/LO. A busy down-counter models the MDU latency. It also raises the
// D-stage stall for MDU instructions while a long operation is in flight.
// Optional feature: define MDU_DIV_EN to build the DIV/DIVU datapath. When it is
// undefined, DIV/DIVU issues are no-ops.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        md_start,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e        state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_ok;

   logic          is_mul, is_div, is_long;
   logic [31:0]   res_hi, res_lo;
   logic          res_ok;
   logic [CW-1:0] load_cnt;
   logic [63:0]   prod;

   // Both operands are zero-extended or sign-extended to 64 bits. The low 64 bits
   // of that product are then the correct signed or unsigned 32x32 result.
   assign prod = (md_op == OP_MULT)
                 ? ({{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b})
                 : ({32'd0, md_a} * {32'd0, md_b});

`ifdef MDU_DIV_EN
   logic        div_signed, neg_q, neg_r;
   logic [31:0] mag_a, mag_b, safe_b, uq, ur;

   // The divider works on magnitudes, and the signs are applied afterwards.
   // This truncates toward zero, and the remainder takes the sign of the dividend.
   // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
   // A zero divisor is replaced by 1 so the datapath never produces X. That
   // result is then dropped through res_ok.
   assign div_signed = (md_op == OP_DIV);
   assign neg_q      = div_signed & (md_a[31] ^ md_b[31]);
   assign neg_r      = div_signed & md_a[31];
   assign mag_a      = (div_signed & md_a[31]) ? (~md_a + 32'd1) : md_a;
   assign mag_b      = (div_signed & md_b[31]) ? (~md_b + 32'd1) : md_b;
   assign safe_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
   assign uq         = mag_a / safe_b;
   assign ur         = mag_a % safe_b;
`endif

   // Decode the E-stage op and pick the pending result and the latency.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
      is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
      is_div   = 1'b0;
      res_hi   = prod[63:32];
      res_lo   = prod[31:0];
      res_ok   = 1'b1;
      load_cnt = CW'(MULT_CYCLES);
`ifdef MDU_DIV_EN
      is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
      if (is_div) begin
         res_hi   = neg_r ? (~ur + 32'd1) : ur;
         res_lo   = neg_q ? (~uq + 32'd1) : uq;
         res_ok   = (md_b != 32'd0);
         load_cnt = CW'(DIV_CYCLES);
      end
`endif
      is_long = is_mul | is_div;
   end

   // Stall is built from the registered busy flag and the E-stage inputs only.
   assign stall = d_is_md & (busy | (md_start & is_long));

   // Sequencer FSM. It owns the counter, HI/LO, the pending result and the registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_ok <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here mean every branch sees pre-edge values of cnt/state.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (md_start) begin
                  if (is_long) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_ok <= res_ok;
                     cnt     <= load_cnt;
                     busy    <= 1'b1;
                     state   <= BUSY;
                  end else if (md_op == OP_MTHI) begin
                     hi <= md_a;
                  end else if (md_op == OP_MTLO) begin
                     lo <= md_a;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (pend_ok) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
